ltl_report_collector: RTL and testbench

- Downstream consumer of the cluster-1 stage-0 automata stage; samples the 12 LTL report wires (ltl0c1/ltl1c1/ltl2c1) every run cycle.
- Timestamps each non-zero report vector with a run-cycle count and queues it in a FIFO.
- The FIFO drains over a valid/ready handshake to the monitor host.
- Also keeps per-report sticky flags and a saturating drop counter for reports lost while the FIFO is full.

---
 rtl/ltl_monitor_pkg.sv | 33 +++
 rtl/ltl_report_fifo.sv | 73 +++++++
 rtl/ltl_report_collector.sv | 84 ++++++++
 tb/tb_ltl_report_collector.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ltl_monitor_pkg.sv
// ltl_monitor_pkg
// Shared definitions for the cluster-1 stage-0 LTL report monitor.
//   NUM_REPORTS     width of the report vector (4 wires x 3 automata)
//   RPT_*           bit position of each automaton output wire in report_vec
//   CNT_W_DEFAULT   default timestamp counter width
//   report_entry_t  one FIFO entry as seen by the host: {timestamp, report_vec}
package ltl_monitor_pkg;

  localparam int NUM_REPORTS   = 12;
  localparam int CNT_W_DEFAULT = 32;

  // ltl0c1
  localparam int RPT_L0_W2 = 0;
  localparam int RPT_L0_W4 = 1;
  localparam int RPT_L0_W7 = 2;
  localparam int RPT_L0_W9 = 3;
  // ltl1c1
  localparam int RPT_L1_W2 = 4;
  localparam int RPT_L1_W4 = 5;
  localparam int RPT_L1_W7 = 6;
  localparam int RPT_L1_W9 = 7;
  // ltl2c1 taps different wires than the other two automata
  localparam int RPT_L2_W3 = 8;
  localparam int RPT_L2_W5 = 9;
  localparam int RPT_L2_W7 = 10;
  localparam int RPT_L2_W9 = 11;

  typedef struct packed {
    logic [CNT_W_DEFAULT-1:0] timestamp;
    logic [NUM_REPORTS-1:0]   report_vec;
  } report_entry_t;

endpackage

// File: rtl/ltl_report_fifo.sv
// ltl_report_fifo
// Synchronous FIFO with a separately tracked occupancy, so full and empty
// are never ambiguous. The head entry is read straight from the storage
// flops, so dout_o is valid the cycle after the first write.
//   clk      clock
//   reset    synchronous active-low reset; flushes contents and storage
//   push_i   write din_i (accepted when not full, or when popping this cycle)
//   pop_i    drop the head entry (ignored when empty)
//   din_i    write data
//   dout_o   head entry
//   full_o / empty_o / level_o   occupancy status
module ltl_report_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 44,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LVL_FULL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign dout_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop  = pop_i && !empty_o;
    // When full, a same-cycle pop frees the slot being written.
    do_push = push_i && (!full_o || do_pop);
    // DEPTH is a power of two, so pointer wrap is plain overflow.
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (do_pop && !do_push) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/ltl_report_collector.sv
// ltl_report_collector
// Samples the 12 LTL report wires of the cluster-1 stage-0 automata on every
// run cycle, stamps non-zero vectors with the run-cycle count and queues them
// for the monitor host. Also keeps sticky report flags and a saturating count
// of reports lost to a full queue.
//   clk, reset          clock, synchronous active-low reset
//   run                 symbol-valid qualifier shared with the automata stage
//   report_vec          report wires (bit order in ltl_monitor_pkg)
//   rpt_valid/ready     head-of-queue handshake to the host
//   rpt_data            {timestamp, report_vec} at the queue head
//   sticky, sticky_clr  accumulated report bits and their clear pulse
//   drop_cnt            reports lost while the queue was full (saturating)
//   fifo_level          queue occupancy
// FIFO_DEPTH must be a power of two, at least 2.
module ltl_report_collector #(
  parameter int NUM_REPORTS = ltl_monitor_pkg::NUM_REPORTS,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = ltl_monitor_pkg::CNT_W_DEFAULT,
  parameter int DROP_W      = 16,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic [NUM_REPORTS-1:0]       report_vec,
  output logic                         rpt_valid,
  input  logic                         rpt_ready,
  output logic [CNT_W+NUM_REPORTS-1:0] rpt_data,
  output logic [NUM_REPORTS-1:0]       sticky,
  input  logic                         sticky_clr,
  output logic [DROP_W-1:0]            drop_cnt,
  output logic [LVL_W-1:0]             fifo_level
);

  import ltl_monitor_pkg::*;

  logic [CNT_W-1:0]       ts_q, ts_d;
  logic [NUM_REPORTS-1:0] sticky_q, sticky_d;
  logic [DROP_W-1:0]      drop_q, drop_d;
  logic                   push_req, drop, fifo_full, fifo_empty;

  always_comb begin
    push_req = run && (report_vec != '0);
    // A full queue only loses the report when the host is not popping.
    drop     = push_req && fifo_full && !rpt_ready;
    ts_d     = run ? ts_q + CNT_W'(1) : ts_q;
    // New report bits win over a coincident clear.
    sticky_d = (sticky_clr ? '0 : sticky_q) | (run ? report_vec : '0);
    drop_d   = (drop && (drop_q != '1)) ? drop_q + DROP_W'(1) : drop_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ts_q     <= '0;
      sticky_q <= '0;
      drop_q   <= '0;
    end else begin
      ts_q     <= ts_d;
      sticky_q <= sticky_d;
      drop_q   <= drop_d;
    end
  end

  // Entry carries the pre-increment count, so the first run cycle is stamp 0.
  ltl_report_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CNT_W + NUM_REPORTS)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_req),
    .pop_i   (rpt_ready),
    .din_i   ({ts_q, report_vec}),
    .dout_o  (rpt_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign rpt_valid = !fifo_empty;
  assign sticky    = sticky_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_ltl_report_collector.sv
module tb_ltl_report_collector;
  import ltl_monitor_pkg::*;

  localparam int DEPTH  = 8;
  localparam int TS_W   = CNT_W_DEFAULT;
  localparam int DR_W   = 16;
  localparam int LV_W   = 4;
  localparam int DATA_W = TS_W + NUM_REPORTS;
  localparam int DROP_MAX = (1 << DR_W) - 1;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   run = 1'b0;
  logic [NUM_REPORTS-1:0] report_vec = '0;
  logic                   rpt_ready = 1'b0;
  logic                   sticky_clr = 1'b0;
  logic                   rpt_valid;
  logic [DATA_W-1:0]      rpt_data;
  logic [NUM_REPORTS-1:0] sticky;
  logic [DR_W-1:0]        drop_cnt;
  logic [LV_W-1:0]        fifo_level;

  ltl_report_collector dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .report_vec (report_vec),
    .rpt_valid  (rpt_valid),
    .rpt_ready  (rpt_ready),
    .rpt_data   (rpt_data),
    .sticky     (sticky),
    .sticky_clr (sticky_clr),
    .drop_cnt   (drop_cnt),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of entries plus counters, updated per edge.
  logic [DATA_W-1:0]      m_q[$];
  logic [TS_W-1:0]        m_ts = '0;
  logic [NUM_REPORTS-1:0] m_sticky = '0;
  int                     m_drop = 0;
  report_entry_t          e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (!reset) begin
      m_q.delete();
      m_ts = '0;
      m_sticky = '0;
      m_drop = 0;
    end else begin
      if (rpt_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (run && report_vec != '0) begin
        if (m_q.size() < DEPTH) m_q.push_back({m_ts, report_vec});
        else if (m_drop < DROP_MAX) m_drop++;
      end
      m_sticky = (sticky_clr ? '0 : m_sticky) | (run ? report_vec : '0);
      if (run) m_ts = m_ts + 1;
    end
  endtask

  task automatic check_all();
    chk("valid", rpt_valid, m_q.size() != 0);
    chk("level", fifo_level, m_q.size());
    chk("sticky", sticky, m_sticky);
    chk("drop", drop_cnt, m_drop);
    if (m_q.size() != 0) chk("data", rpt_data, m_q[0]);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    run = 1'b0;
    report_vec = '0;
    sticky_clr = 1'b0;
    cyc();
    reset = 1'b1;
  endtask

  initial begin
    #2;
    do_reset();
    chk("rst_valid", rpt_valid, 1'b0);
    chk("rst_data", rpt_data, '0);
    chk("rst_level", fifo_level, 4'd0);

    // 1: single report on the 4th run cycle
    rpt_ready = 1'b1;
    run = 1'b1;
    report_vec = '0;
    repeat (3) cyc();
    report_vec = 12'h001;
    cyc();
    run = 1'b0;
    report_vec = '0;
    chk("t1_valid", rpt_valid, 1'b1);
    chk("t1_data", rpt_data, {32'd3, 12'h001});
    chk("t1_sticky", sticky, 12'h001);
    cyc();
    chk("t1_valid_once", rpt_valid, 1'b0);

    // 2: gap in run
    do_reset();
    rpt_ready = 1'b0;
    report_vec = 12'h800;
    run = 1'b1; cyc();
    run = 1'b0; cyc();
    run = 1'b1; cyc();
    run = 1'b0;
    report_vec = '0;
    chk("t2_level", fifo_level, 4'd2);
    e = rpt_data;
    chk("t2_ts0", e.timestamp, 32'd0);
    rpt_ready = 1'b1;
    cyc();
    e = rpt_data;
    chk("t2_ts1", e.timestamp, 32'd1);
    cyc();
    chk("t2_empty", rpt_valid, 1'b0);

    // 3: overflow
    do_reset();
    rpt_ready = 1'b0;
    run = 1'b1;
    report_vec = 12'h010;
    repeat (11) cyc();
    run = 1'b0;
    report_vec = '0;
    chk("t3_level", fifo_level, 4'd8);
    chk("t3_drop", drop_cnt, 16'd3);
    rpt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e = rpt_data;
      chk("t3_drain_ts", e.timestamp, i);
      cyc();
    end
    chk("t3_empty", rpt_valid, 1'b0);

    // 4: full with simultaneous pop
    do_reset();
    rpt_ready = 1'b0;
    run = 1'b1;
    report_vec = 12'h010;
    repeat (8) cyc();
    report_vec = 12'h020;
    rpt_ready = 1'b1;
    cyc();
    run = 1'b0;
    report_vec = '0;
    chk("t4_level", fifo_level, 4'd8);
    chk("t4_drop", drop_cnt, 16'd0);
    repeat (7) cyc();
    chk("t4_last", rpt_data, {32'd8, 12'h020});
    cyc();
    chk("t4_empty", rpt_valid, 1'b0);

    // 5: sticky clear collides with a new report
    do_reset();
    rpt_ready = 1'b0;
    run = 1'b1;
    report_vec = 12'h0F0;
    cyc();
    chk("t5_sticky_pre", sticky, 12'h0F0);
    sticky_clr = 1'b1;
    report_vec = 12'h100;
    cyc();
    sticky_clr = 1'b0;
    run = 1'b0;
    report_vec = '0;
    chk("t5_sticky", sticky, 12'h100);

    // 6: reset mid-operation
    do_reset();
    rpt_ready = 1'b0;
    run = 1'b1;
    report_vec = 12'h001;
    repeat (10) cyc();
    run = 1'b0;
    report_vec = '0;
    rpt_ready = 1'b1;
    repeat (3) cyc();
    rpt_ready = 1'b0;
    chk("t6_level_pre", fifo_level, 4'd5);
    chk("t6_drop_pre", drop_cnt, 16'd2);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk("t6_valid", rpt_valid, 1'b0);
    chk("t6_level", fifo_level, 4'd0);
    chk("t6_drop", drop_cnt, 16'd0);
    chk("t6_sticky", sticky, 12'h000);
    chk("t6_data", rpt_data, '0);
    run = 1'b1;
    report_vec = 12'h004;
    cyc();
    run = 1'b0;
    report_vec = '0;
    e = rpt_data;
    chk("t6_ts", e.timestamp, 32'd0);
    chk("t6_vec", e.report_vec, 12'h004);

    // Randomised traffic against the model, with bursts of back-pressure.
    for (int i = 0; i < 600; i++) begin
      run        = ($urandom_range(0, 3) != 0);
      report_vec = ($urandom_range(0, 2) == 0) ? '0 : NUM_REPORTS'($urandom);
      rpt_ready  = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      sticky_clr = ($urandom_range(0, 15) == 0);
      reset      = ($urandom_range(0, 199) != 0);
      cyc();
    end
    reset = 1'b1;
    run = 1'b0;
    report_vec = '0;
    sticky_clr = 1'b0;
    rpt_ready = 1'b1;
    repeat (10) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
